// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Forwarding select encodings and the controller state enum live here.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RST_FLUSH = 2'd0,
        ST_RUN       = 2'd1,
        ST_LU_STALL  = 2'd2,
        ST_MC_WAIT   = 2'd3
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic ifid_flush;
        logic idex_stall;
        logic idex_flush;
        logic mc_start;
    } ctl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: decoder/pipeline stage info in, stall/flush/forward controls out.
// master = pipeline side, slave = hazard controller.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] id_rR1_i;
    logic [REG_AW-1:0] id_rR2_i;
    logic              id_re1_i;
    logic              id_re2_i;
    logic [REG_AW-1:0] ex_wR_i;
    logic              ex_rf_we_i;
    logic              ex_is_load_i;
    logic              ex_mc_i;
    logic              ex_jump_i;
    logic [REG_AW-1:0] mem_wR_i;
    logic              mem_rf_we_i;
    logic [REG_AW-1:0] wb_wR_i;
    logic              wb_rf_we_i;
    logic              mc_done_i;

    logic              pc_stall_o;
    logic              ifid_stall_o;
    logic              ifid_flush_o;
    logic              idex_stall_o;
    logic              idex_flush_o;
    logic [1:0]        fwd_a_o;
    logic [1:0]        fwd_b_o;
    logic              mc_start_o;
    logic              mc_err_o;

    modport master (
        output id_rR1_i, id_rR2_i, id_re1_i, id_re2_i,
        output ex_wR_i, ex_rf_we_i, ex_is_load_i, ex_mc_i, ex_jump_i,
        output mem_wR_i, mem_rf_we_i, wb_wR_i, wb_rf_we_i, mc_done_i,
        input  pc_stall_o, ifid_stall_o, ifid_flush_o, idex_stall_o, idex_flush_o,
        input  fwd_a_o, fwd_b_o, mc_start_o, mc_err_o
    );

    modport slave (
        input  id_rR1_i, id_rR2_i, id_re1_i, id_re2_i,
        input  ex_wR_i, ex_rf_we_i, ex_is_load_i, ex_mc_i, ex_jump_i,
        input  mem_wR_i, mem_rf_we_i, wb_wR_i, wb_rf_we_i, mc_done_i,
        output pc_stall_o, ifid_stall_o, ifid_flush_o, idex_stall_o, idex_flush_o,
        output fwd_a_o, fwd_b_o, mc_start_o, mc_err_o
    );

endinterface

// File: rtl/pipe_hazard_ctrl_mc_watchdog.sv
// mc_watchdog: cycle counter for an in-flight multi-cycle op, pulses timeout at MC_TO.
// clr has priority over start (load 1) over enable (increment).
module mc_watchdog #(
    parameter int MC_TO = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic start_i,
    input  logic en_i,
    output logic timeout_o
);
    localparam int CW = $clog2(MC_TO + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (start_i) begin
            cnt_d = CW'(1);
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = en_i && (cnt_q == CW'(MC_TO));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forward sequencing for IF/ID and ID/EX of the 5-stage core.
// Define PIPE_FWD_EN for EX/MEM operand forwarding; without it every RAW hazard stalls.
//
// state      | meaning
// RST_FLUSH  | reset held, or first cycle after release: bubble both registers
// RUN        | normal hazard evaluation (jump > multi-cycle > RAW stall > forward)
// LU_STALL   | single bubble inserted behind a load; load now sits in MEM
// MC_WAIT    | whole front end held while the multi-cycle unit works
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MC_TO  = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    pipe_hazard_ctrl_if.slave  hz
);

    function automatic logic reg_hit(input logic re, input logic we,
                                     input logic [REG_AW-1:0] src,
                                     input logic [REG_AW-1:0] dst);
        return re && we && (src != '0) && (src == dst);
    endfunction

    state_e     state_q, state_d;
    logic       err_q, err_d;
    ctl_t       ctl;
    logic [1:0] fwd_a, fwd_b;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b;
    logic       raw_stall;
    logic       wd_clr, wd_start, wd_en, wd_timeout;

    assign hit_ex_a  = reg_hit(hz.id_re1_i, hz.ex_rf_we_i,  hz.id_rR1_i, hz.ex_wR_i);
    assign hit_ex_b  = reg_hit(hz.id_re2_i, hz.ex_rf_we_i,  hz.id_rR2_i, hz.ex_wR_i);
    assign hit_mem_a = reg_hit(hz.id_re1_i, hz.mem_rf_we_i, hz.id_rR1_i, hz.mem_wR_i);
    assign hit_mem_b = reg_hit(hz.id_re2_i, hz.mem_rf_we_i, hz.id_rR2_i, hz.mem_wR_i);

`ifdef PIPE_FWD_EN
    // Youngest producer wins: EX result is newer than MEM.
    assign fwd_a_sel = hit_ex_a ? FWD_EX : (hit_mem_a ? FWD_MEM : FWD_RF);
    assign fwd_b_sel = hit_ex_b ? FWD_EX : (hit_mem_b ? FWD_MEM : FWD_RF);
    assign raw_stall = hz.ex_is_load_i && (hit_ex_a || hit_ex_b);

    logic unused_wb;
    assign unused_wb = ^{hz.wb_wR_i, hz.wb_rf_we_i};
`else
    logic hit_wb_a, hit_wb_b;
    assign hit_wb_a  = reg_hit(hz.id_re1_i, hz.wb_rf_we_i, hz.id_rR1_i, hz.wb_wR_i);
    assign hit_wb_b  = reg_hit(hz.id_re2_i, hz.wb_rf_we_i, hz.id_rR2_i, hz.wb_wR_i);
    assign fwd_a_sel = FWD_RF;
    assign fwd_b_sel = FWD_RF;
    assign raw_stall = hit_ex_a || hit_ex_b || hit_mem_a || hit_mem_b || hit_wb_a || hit_wb_b;

    logic unused_ld;
    assign unused_ld = hz.ex_is_load_i;
`endif

    assign wd_en = rst_i && (state_q == ST_MC_WAIT);

    mc_watchdog #(
        .MC_TO (MC_TO)
    ) u_mc_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (wd_clr),
        .start_i   (wd_start),
        .en_i      (wd_en),
        .timeout_o (wd_timeout)
    );

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        ctl      = '0;
        fwd_a    = FWD_RF;
        fwd_b    = FWD_RF;
        wd_clr   = 1'b0;
        wd_start = 1'b0;
        if (!rst_i) begin
            state_d        = ST_RST_FLUSH;
            err_d          = 1'b0;
            wd_clr         = 1'b1;
            ctl.ifid_flush = 1'b1;
            ctl.idex_flush = 1'b1;
        end else begin
            case (state_q)
                ST_RST_FLUSH: begin
                    ctl.ifid_flush = 1'b1;
                    ctl.idex_flush = 1'b1;
                    state_d        = ST_RUN;
                end
                ST_RUN: begin
                    if (hz.ex_jump_i) begin
                        ctl.ifid_flush = 1'b1;
                        ctl.idex_flush = 1'b1;
                    end else if (hz.ex_mc_i) begin
                        ctl.mc_start   = 1'b1;
                        ctl.pc_stall   = 1'b1;
                        ctl.ifid_stall = 1'b1;
                        ctl.idex_stall = 1'b1;
                        wd_start       = 1'b1;
                        state_d        = ST_MC_WAIT;
                    end else if (raw_stall) begin
                        ctl.pc_stall   = 1'b1;
                        ctl.ifid_stall = 1'b1;
                        ctl.idex_flush = 1'b1;
`ifdef PIPE_FWD_EN
                        state_d        = ST_LU_STALL;
`endif
                    end else begin
                        fwd_a = fwd_a_sel;
                        fwd_b = fwd_b_sel;
                    end
                end
                ST_LU_STALL: begin
                    fwd_a   = fwd_a_sel;
                    fwd_b   = fwd_b_sel;
                    state_d = ST_RUN;
                end
                ST_MC_WAIT: begin
                    // Done beats a same-cycle timeout; jumps cannot resolve while EX is held.
                    if (hz.mc_done_i) begin
                        fwd_a   = fwd_a_sel;
                        fwd_b   = fwd_b_sel;
                        wd_clr  = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        ctl.pc_stall   = 1'b1;
                        ctl.ifid_stall = 1'b1;
                        ctl.idex_stall = 1'b1;
                        if (wd_timeout) begin
                            err_d   = 1'b1;
                            wd_clr  = 1'b1;
                            state_d = ST_RUN;
                        end
                    end
                end
                default: state_d = ST_RST_FLUSH;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_RST_FLUSH;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign hz.pc_stall_o   = ctl.pc_stall;
    assign hz.ifid_stall_o = ctl.ifid_stall;
    assign hz.ifid_flush_o = ctl.ifid_flush;
    assign hz.idex_stall_o = ctl.idex_stall;
    assign hz.idex_flush_o = ctl.idex_flush;
    assign hz.mc_start_o   = ctl.mc_start;
    assign hz.fwd_a_o      = fwd_a;
    assign hz.fwd_b_o      = fwd_b;
    assign hz.mc_err_o     = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table for single-cycle hazard decode,
// hand sequences for reset, load-use, jump, multi-cycle done/timeout. Expectations track PIPE_FWD_EN.
module tb_pipe_hazard_ctrl;

    // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, fwd_a[1:0], fwd_b[1:0], mc_start, mc_err}
    localparam logic [10:0] O_IDLE  = 11'b00000_00_00_00;
    localparam logic [10:0] O_FLUSH = 11'b00101_00_00_00;
    localparam logic [10:0] O_LU    = 11'b11001_00_00_00;
    localparam logic [10:0] O_MCST  = 11'b11010_00_00_10;
    localparam logic [10:0] O_MCW   = 11'b11010_00_00_00;
    localparam logic [10:0] O_ERR   = 11'b00000_00_00_01;

    typedef struct {
        logic [4:0]  r1, r2;
        logic        re1, re2;
        logic [4:0]  exw;
        logic        exwe, exld;
        logic [4:0]  memw;
        logic        memwe;
        logic [4:0]  wbw;
        logic        wbwe;
        logic        jmp;
        logic [10:0] exp_f;
        logic [10:0] exp_n;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    vec_t tbl [16];

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_AW(5)) hz ();

    pipe_hazard_ctrl #(
        .REG_AW (5),
        .MC_TO  (8)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .hz    (hz)
    );

    function automatic logic [10:0] fw(input logic [1:0] a, input logic [1:0] b);
        return {5'b0, a, b, 2'b0};
    endfunction

    function automatic vec_t mkv(input logic [4:0] r1, input logic [4:0] r2,
                                 input logic re1, input logic re2,
                                 input logic [4:0] exw, input logic exwe, input logic exld,
                                 input logic [4:0] memw, input logic memwe,
                                 input logic [4:0] wbw, input logic wbwe, input logic jmp,
                                 input logic [10:0] ef, input logic [10:0] en);
        vec_t v;
        v.r1 = r1; v.r2 = r2; v.re1 = re1; v.re2 = re2;
        v.exw = exw; v.exwe = exwe; v.exld = exld;
        v.memw = memw; v.memwe = memwe; v.wbw = wbw; v.wbwe = wbwe;
        v.jmp = jmp; v.exp_f = ef; v.exp_n = en;
        return v;
    endfunction

    function automatic logic [10:0] outs();
        return {hz.pc_stall_o, hz.ifid_stall_o, hz.ifid_flush_o, hz.idex_stall_o,
                hz.idex_flush_o, hz.fwd_a_o, hz.fwd_b_o, hz.mc_start_o, hz.mc_err_o};
    endfunction

    function automatic logic [10:0] pick(input logic [10:0] ef, input logic [10:0] en);
`ifdef PIPE_FWD_EN
        return ef;
`else
        return en;
`endif
    endfunction

    task automatic set_idle();
        hz.id_rR1_i = '0; hz.id_rR2_i = '0; hz.id_re1_i = 1'b0; hz.id_re2_i = 1'b0;
        hz.ex_wR_i = '0; hz.ex_rf_we_i = 1'b0; hz.ex_is_load_i = 1'b0;
        hz.ex_mc_i = 1'b0; hz.ex_jump_i = 1'b0;
        hz.mem_wR_i = '0; hz.mem_rf_we_i = 1'b0;
        hz.wb_wR_i = '0; hz.wb_rf_we_i = 1'b0;
        hz.mc_done_i = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        set_idle();
        hz.id_rR1_i = v.r1; hz.id_rR2_i = v.r2; hz.id_re1_i = v.re1; hz.id_re2_i = v.re2;
        hz.ex_wR_i = v.exw; hz.ex_rf_we_i = v.exwe; hz.ex_is_load_i = v.exld;
        hz.mem_wR_i = v.memw; hz.mem_rf_we_i = v.memwe;
        hz.wb_wR_i = v.wbw; hz.wb_rf_we_i = v.wbwe; hz.ex_jump_i = v.jmp;
    endtask

    task automatic chk(input string nm, input logic [10:0] exp);
        logic [10:0] got;
        #2;
        got = outs();
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b want=%b", nm, got, exp);
        end
    endtask

    initial begin
        tbl[0]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE, O_IDLE);
        tbl[1]  = mkv(5, 0, 1, 0, 5, 1, 0, 0, 0, 0, 0, 0, fw(2'b01, 2'b00), O_LU);
        tbl[2]  = mkv(5, 0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, fw(2'b10, 2'b00), O_LU);
        tbl[3]  = mkv(5, 0, 1, 0, 5, 1, 0, 5, 1, 0, 0, 0, fw(2'b01, 2'b00), O_LU);
        tbl[4]  = mkv(0, 0, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0, O_IDLE, O_IDLE);
        tbl[5]  = mkv(0, 5, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, fw(2'b00, 2'b01), O_LU);
        tbl[6]  = mkv(5, 0, 0, 0, 5, 1, 0, 5, 1, 5, 1, 0, O_IDLE, O_IDLE);
        tbl[7]  = mkv(5, 5, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, O_IDLE, O_IDLE);
        tbl[8]  = mkv(5, 0, 1, 0, 0, 0, 0, 0, 0, 5, 1, 0, O_IDLE, O_LU);
        tbl[9]  = mkv(3, 4, 1, 1, 3, 1, 0, 4, 1, 0, 0, 0, fw(2'b01, 2'b10), O_LU);
        tbl[10] = mkv(0, 7, 0, 1, 7, 1, 1, 0, 0, 0, 0, 0, O_LU, O_LU);
        tbl[11] = mkv(8, 8, 1, 1, 7, 1, 1, 0, 0, 0, 0, 0, O_IDLE, O_IDLE);
        tbl[12] = mkv(6, 7, 1, 0, 7, 1, 1, 6, 1, 0, 0, 0, fw(2'b10, 2'b00), O_LU);
        tbl[13] = mkv(5, 5, 1, 1, 5, 1, 0, 5, 1, 5, 1, 1, O_FLUSH, O_FLUSH);
        tbl[14] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_FLUSH, O_FLUSH);
        tbl[15] = mkv(5, 9, 1, 1, 9, 1, 0, 5, 1, 0, 0, 0, fw(2'b10, 2'b01), O_LU);

        // reset held, then released: flush persists for the first cycle after release
        rst = 1'b0;
        set_idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rst_hold%0d", k), O_FLUSH);
        end
        @(negedge clk);
        rst = 1'b1;
        chk("rst_release", O_FLUSH);
        @(negedge clk);
        chk("run_idle", O_IDLE);

        // single-cycle hazard decode, each vector followed by one idle cycle
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            chk($sformatf("vec%0d", i), pick(tbl[i].exp_f, tbl[i].exp_n));
            @(negedge clk);
            set_idle();
        end

        // x7 producer walks EX(load) -> MEM -> WB while ID keeps reading x7 on rR2
        @(negedge clk);
        set_idle();
        hz.id_rR2_i = 5'd7; hz.id_re2_i = 1'b1;
        hz.ex_wR_i = 5'd7; hz.ex_rf_we_i = 1'b1; hz.ex_is_load_i = 1'b1;
        chk("lu_c1", O_LU);
        @(negedge clk);
        hz.ex_wR_i = '0; hz.ex_rf_we_i = 1'b0; hz.ex_is_load_i = 1'b0;
        hz.mem_wR_i = 5'd7; hz.mem_rf_we_i = 1'b1;
        chk("lu_c2", pick(fw(2'b00, 2'b10), O_LU));
        @(negedge clk);
        hz.mem_wR_i = '0; hz.mem_rf_we_i = 1'b0;
        hz.wb_wR_i = 5'd7; hz.wb_rf_we_i = 1'b1;
        chk("lu_c3", pick(O_IDLE, O_LU));
        @(negedge clk);
        hz.wb_wR_i = '0; hz.wb_rf_we_i = 1'b0;
        chk("lu_c4", O_IDLE);

        // jump with concurrent load-use: flush only, controller stays in RUN
        @(negedge clk);
        set_idle();
        hz.id_rR2_i = 5'd7; hz.id_re2_i = 1'b1;
        hz.ex_wR_i = 5'd7; hz.ex_rf_we_i = 1'b1; hz.ex_is_load_i = 1'b1;
        hz.ex_jump_i = 1'b1;
        chk("jmp_lu", O_FLUSH);
        @(negedge clk);
        hz.ex_jump_i = 1'b0;
        chk("jmp_after", O_LU);
        @(negedge clk);
        set_idle();
        @(negedge clk);

        // multi-cycle op, done after 5 wait cycles; a jump mid-wait is ignored
        hz.ex_mc_i = 1'b1;
        chk("mc_start", O_MCST);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            hz.ex_jump_i = (k == 3);
            chk($sformatf("mc_wait%0d", k), O_MCW);
        end
        @(negedge clk);
        hz.ex_jump_i = 1'b0;
        hz.mc_done_i = 1'b1;
        chk("mc_done", O_IDLE);
        @(negedge clk);
        hz.ex_mc_i = 1'b0;
        chk("mc_done_in_run", O_IDLE);
        @(negedge clk);
        hz.mc_done_i = 1'b0;
        chk("mc_after", O_IDLE);

        // watchdog timeout at MC_TO=8: sticky error, second op does not clear it
        @(negedge clk);
        hz.ex_mc_i = 1'b1;
        chk("to_start", O_MCST);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("to_wait%0d", k), O_MCW);
        end
        @(negedge clk);
        hz.ex_mc_i = 1'b0;
        chk("to_err", O_ERR);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("to_sticky%0d", k), O_ERR);
        end
        @(negedge clk);
        hz.ex_mc_i = 1'b1;
        chk("to_mc2_start", O_MCST | O_ERR);
        @(negedge clk);
        hz.mc_done_i = 1'b1;
        chk("to_mc2_done", O_ERR);
        @(negedge clk);
        set_idle();
        chk("to_mc2_after", O_ERR);

        // reset in the middle of MC_WAIT abandons the op and clears the error
        @(negedge clk);
        hz.ex_mc_i = 1'b1;
        chk("rmc_start", O_MCST | O_ERR);
        @(negedge clk);
        chk("rmc_wait1", O_MCW | O_ERR);
        @(negedge clk);
        chk("rmc_wait2", O_MCW | O_ERR);
        @(negedge clk);
        rst = 1'b0;
        hz.ex_mc_i = 1'b0;
        @(negedge clk);
        chk("rmc_rst", O_FLUSH);
        @(negedge clk);
        rst = 1'b1;
        chk("rmc_release", O_FLUSH);
        @(negedge clk);
        chk("rmc_run", O_IDLE);

        // done arriving on the timeout cycle wins: no error
        @(negedge clk);
        hz.ex_mc_i = 1'b1;
        chk("edge_start", O_MCST);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk($sformatf("edge_wait%0d", k), O_MCW);
        end
        @(negedge clk);
        hz.mc_done_i = 1'b1;
        chk("edge_done", O_IDLE);
        @(negedge clk);
        set_idle();
        chk("edge_noerr", O_IDLE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
